xdma_c2h_pkt_buffer: RTL and testbench
======================================

// Module: xdma_c2h_pkt_buffer
// PURPOSE
//  Store-and-forward 512-bit AXI-Stream packet buffer on the C2H path, UDP/IP/ARP/Eth RX output -> XDMA s_axis_c2h_0.
//  Gives XDMA only complete, error-free packets. Bad or overflowing packets are dropped whole.
//  The UDP side is never back-pressured. Single clock domain (XDMA axi_aclk).
// PARAMETERS
//  DATA_WIDTH  512  tdata width in bits
//  KEEP_WIDTH  64   tkeep width (DATA_WIDTH/8)
//  DEPTH_LOG2  9    buffer depth = 2**DEPTH_LOG2 beats (32 KiB at defaults)
// PORTS
//  xdma_clk             in   1           clock (XDMA axi_aclk)
//  xdma_reset           in   1           asynchronous, active-low reset
//  s_axis_tvalid        in   1           beat valid from UDP RX
//  s_axis_tready        out  1           always 1 out of reset
//  s_axis_tdata         in   DATA_WIDTH  payload
//  s_axis_tkeep         in   KEEP_WIDTH  byte enables
//  s_axis_tlast         in   1           end of packet
//  s_axis_tuser         in   1           error flag; sampled on the tlast beat only
//  m_axis_tvalid        out  1           to XDMA s_axis_c2h_tvalid_0
//  m_axis_tready        in   1           from XDMA s_axis_c2h_tready_0
//  m_axis_tdata         out  DATA_WIDTH
//  m_axis_tkeep         out  KEEP_WIDTH
//  m_axis_tlast         out  1
// BEHAVIOUR
//  Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, tdata/tkeep=0. All pointers=0. State=IDLE.
//  s_axis_tready goes to 1 on the first clock edge after reset deassert.
//  Pointers wr_ptr, wr_commit, rd_ptr are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1).
//  Full: wr_ptr - rd_ptr == 2**DEPTH_LOG2.
//  Empty (read side): rd_ptr == wr_commit.
//  Write FSM (accepted beat = s_axis_tvalid & s_axis_tready):
//   IDLE/PKT: not full -> write {tlast,tkeep,tdata} at wr_ptr, wr_ptr++.
//     Full while a beat is accepted -> discard that beat, go to DROP.
//   PKT, tlast beat:
//     tuser=0 -> wr_commit <= wr_ptr+1 (the packet becomes visible), go to IDLE.
//     tuser=1 -> wr_ptr <= wr_commit (rewind), go to IDLE.
//   DROP: discard all beats. On tlast: wr_ptr <= wr_commit, go to IDLE.
//   A 1-beat packet (tlast on first beat) commits or rewinds in that same cycle.
//  Packets longer than 2**DEPTH_LOG2 beats are always dropped. No deadlock.
//  Read side: 1-cycle RAM read feeding a 2-entry output skid, so a full-rate stream is possible.
//   m_axis_tvalid rises 2 cycles after the cycle in which wr_commit advances over an empty buffer.
//   rd_ptr advances on RAM read issue.
//   The skid never drops or duplicates a beat. Output is held stable while tvalid=1 & tready=0.
//   Sustains 1 beat/cycle with m_axis_tready=1.
//  Simultaneous commit and read in the same cycle: both take effect.
//   The full test uses the current rd_ptr, so it is conservative by at most 1 cycle.
//  Reset asserted mid-packet: all state is cleared asynchronously and buffered packets are lost.
//   After release the write FSM starts in IDLE. If the UDP side resumes mid-packet, that tail is taken as a new packet.
// CONFIGURATION
//  XDMA_C2H_DROP_CNT_EN defined:
//   Adds output drop_cnt [31:0], reset 0.
//   +1 per dropped packet (error or overflow), counted on its tlast beat. Saturates at 32'hFFFF_FFFF.
//  Not defined: no drop_cnt port and no counter logic. Drops are silent.
// STRUCTURE
//  Package xdma_axis_pkg:
//   XDMA_AXIS_TDATA_WIDTH=512, XDMA_AXIS_TKEEP_WIDTH=64, XDMA_AXIS_TUSER_WIDTH=1.
//   Typedef axis_beat_t {tlast,tkeep,tdata}.
//   Enum wr_state_e {IDLE,PKT,DROP}.
//  Sub-module xdma_c2h_sdp_ram: simple dual-port RAM, 1 write port and 1 read port.
//   Synchronous read, 1-cycle latency, width $bits(axis_beat_t), depth 2**DEPTH_LOG2.
//   No reset on the array.
// TESTING
//  1. Good 3-beat packet, tuser=0, tkeep last=64'h0000_0000_FFFF_FFFF, m_axis_tready=1
//     -> same 3 beats out, tlast on beat 3 only; tvalid 2 cycles after the input tlast.
//  2. 4-beat packet with tuser=1 on tlast, then a good 2-beat packet
//     -> only the 2-beat packet appears; drop_cnt=1 when XDMA_C2H_DROP_CNT_EN is defined.
//  3. DEPTH_LOG2=4, m_axis_tready=0, 20-beat packet
//     -> packet dropped, no output; a following 8-beat packet is delivered intact after tready=1.
//  4. 100 back-to-back 1-beat packets, m_axis_tready=1 -> 100 beats out, no gaps after the first, none lost.
//  5. Random m_axis_tready (50%) with 200 random packets of 1-12 beats
//     -> scoreboard match, output stable while stalled, s_axis_tready never 0.
//  6. Assert xdma_reset=0 on beat 2 of a 5-beat packet
//     -> m_axis_tvalid=0 immediately; after release, a new 3-beat packet passes alone.

Source files
------------

// File: rtl/xdma_axis_pkg.sv
// rtl/xdma_axis_pkg.sv - shared beat type, widths and write-FSM states for the C2H packet buffer
package xdma_axis_pkg;
    localparam int XDMA_AXIS_TDATA_WIDTH = 512;
    localparam int XDMA_AXIS_TKEEP_WIDTH = 64;
    localparam int XDMA_AXIS_TUSER_WIDTH = 1;

    typedef struct packed {
        logic                             tlast;
        logic [XDMA_AXIS_TKEEP_WIDTH-1:0] tkeep;
        logic [XDMA_AXIS_TDATA_WIDTH-1:0] tdata;
    } axis_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DROP
    } wr_state_e;
endpackage

// File: rtl/xdma_c2h_sdp_ram.sv
// rtl/xdma_c2h_sdp_ram.sv - simple dual-port RAM, one write and one registered read port, no array reset
module xdma_c2h_sdp_ram #(
    parameter int WIDTH      = 577,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);
    logic [WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/xdma_c2h_pkt_buffer.sv
// rtl/xdma_c2h_pkt_buffer.sv - store-and-forward C2H packet buffer; XDMA_C2H_DROP_CNT_EN adds drop_cnt
module xdma_c2h_pkt_buffer
    import xdma_axis_pkg::*;
#(
    parameter int DATA_WIDTH = XDMA_AXIS_TDATA_WIDTH,
    parameter int KEEP_WIDTH = XDMA_AXIS_TKEEP_WIDTH,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                             xdma_clk,
    input  logic                             xdma_reset,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic [XDMA_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
`ifdef XDMA_C2H_DROP_CNT_EN
    output logic [31:0]                      drop_cnt,
`endif
    output logic                             m_axis_tlast
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_e     r_state, w_state_nxt;
    logic [PW-1:0] r_wr_ptr, r_wr_commit, r_rd_ptr;
    logic [PW-1:0] w_wr_ptr_nxt, w_wr_commit_nxt;
    logic          r_s_tready;
    logic          w_acc, w_full, w_wr_en;
    axis_beat_t    w_in_beat, w_ram_q, w_out_beat;
    axis_beat_t    r_skid [2];
    logic          r_ram_vld, r_hd;
    logic [1:0]    r_cnt;
    logic          w_out_vld, w_pop, w_pop_skid, w_push, w_rd_en;

    assign w_acc     = s_axis_tvalid & r_s_tready;
    assign w_full    = (r_wr_ptr - r_rd_ptr) == DEPTH;
    assign w_in_beat = '{tlast: s_axis_tlast, tkeep: s_axis_tkeep, tdata: s_axis_tdata};

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_commit_nxt = r_wr_commit;
        w_wr_en         = 1'b0;
        if (w_acc) begin
            case (r_state)
                IDLE, PKT: begin
                    if (w_full) begin
                        // an overflowing tlast beat must not leave us in DROP, or the next packet is lost
                        if (s_axis_tlast) begin
                            w_wr_ptr_nxt = r_wr_commit;
                            w_state_nxt  = IDLE;
                        end else begin
                            w_state_nxt = DROP;
                        end
                    end else begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
                        w_state_nxt  = PKT;
                        if (s_axis_tlast) begin
                            w_state_nxt = IDLE;
                            if (s_axis_tuser[0]) w_wr_ptr_nxt    = r_wr_commit;
                            else                 w_wr_commit_nxt = r_wr_ptr + PW'(1);
                        end
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        w_wr_ptr_nxt = r_wr_commit;
                        w_state_nxt  = IDLE;
                    end
                end
            endcase
        end
    end

    xdma_c2h_sdp_ram #(
        .WIDTH      ($bits(axis_beat_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .i_clk     (xdma_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wr_data (w_in_beat),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_ram_q)
    );

    // RAM output bypasses an empty skid so tvalid rises two cycles after commit
    assign w_out_vld  = (r_cnt != 2'd0) | r_ram_vld;
    assign w_out_beat = (r_cnt != 2'd0) ? r_skid[r_hd] : w_ram_q;
    assign w_pop      = w_out_vld & m_axis_tready;
    assign w_pop_skid = w_pop & (r_cnt != 2'd0);
    assign w_push     = r_ram_vld & ~(w_pop & (r_cnt == 2'd0));
    // issue only if the beat will find a free skid slot when it lands
    assign w_rd_en    = (r_rd_ptr != r_wr_commit)
                      & (((r_cnt + {1'b0, r_ram_vld}) != 2'd2) | w_pop);

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset) begin
            r_s_tready  <= 1'b0;
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_ram_vld   <= 1'b0;
            r_cnt       <= 2'd0;
            r_hd        <= 1'b0;
        end else begin
            r_s_tready  <= 1'b1;
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_ram_vld   <= w_rd_en;
            r_cnt       <= r_cnt + {1'b0, w_push} - {1'b0, w_pop_skid};
            if (w_pop_skid) r_hd <= ~r_hd;
        end
    end

    always_ff @(posedge xdma_clk) begin
        if (w_push) r_skid[r_hd ^ r_cnt[0]] <= w_ram_q;
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = w_out_vld;
    assign m_axis_tdata  = w_out_vld ? w_out_beat.tdata : '0;
    assign m_axis_tkeep  = w_out_vld ? w_out_beat.tkeep : '0;
    assign m_axis_tlast  = w_out_vld & w_out_beat.tlast;

`ifdef XDMA_C2H_DROP_CNT_EN
    logic w_drop;
    assign w_drop = w_acc & s_axis_tlast & ((r_state == DROP) | w_full | s_axis_tuser[0]);

    always_ff @(posedge xdma_clk or negedge xdma_reset) begin
        if (!xdma_reset)                     drop_cnt <= 32'd0;
        else if (w_drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_xdma_c2h_pkt_buffer.sv
// tb/tb_xdma_c2h_pkt_buffer.sv - directed self-checking bench for xdma_c2h_pkt_buffer (DEPTH_LOG2=4)
module tb_xdma_c2h_pkt_buffer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic [0:0]   s_axis_tuser;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
`ifdef XDMA_C2H_DROP_CNT_EN
    logic [31:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_base  = 0;
    int exp_drops = 0;
    int n_hold_ev = 0;
    int n_hold_bad = 0;
    logic [576:0] exp_q [$];
    logic [576:0] rx_q [$];
    int           rx_cyc [$];
    logic [577:0] mon_prev;
    logic         mon_stall = 1'b0;
    logic         t5_done;

    xdma_c2h_pkt_buffer #(.DEPTH_LOG2(4)) dut (
        .xdma_clk      (clk),
        .xdma_reset    (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
`ifdef XDMA_C2H_DROP_CNT_EN
        .drop_cnt      (drop_cnt),
`endif
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_stall = 1'b0;
        end else begin
            if (mon_stall) begin
                n_hold_ev++;
                if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== mon_prev) n_hold_bad++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                rx_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                rx_cyc.push_back(cyc);
            end
            mon_stall = m_axis_tvalid && !m_axis_tready;
            mon_prev  = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_data(input int p, input int b);
        for (int i = 0; i < 16; i++) mk_data[i*32 +: 32] = 32'(p * 4096 + b * 16 + i);
    endfunction

    task automatic send_pkt(input int p, input int n, input logic err, input logic [63:0] last_keep,
                            input logic mid_user, input logic keep_it);
        check("s_tready", s_axis_tready, 1);
        for (int b = 0; b < n; b++) begin
            s_axis_tdata  = mk_data(p, b);
            s_axis_tkeep  = (b == n - 1) ? last_keep : '1;
            s_axis_tlast  = (b == n - 1);
            s_axis_tuser  = (b == n - 1) ? err : mid_user;
            s_axis_tvalid = 1'b1;
            if (keep_it) exp_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        for (int c = 0; c < 300 && (rx_q.size() - rx_base < exp_q.size()); c++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        n = rx_q.size() - rx_base;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) check({tag, "_beat"}, rx_q[rx_base + i], exp_q[i]);
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        int base, good, len;
        logic err;
        logic [63:0] k;
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; m_axis_tready = 1'b1; t5_done = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tkeep", m_axis_tkeep, 0);
`ifdef XDMA_C2H_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt, 0);
`endif
        #2 rst_n = 1'b1;
        #1 check("rel_s_tready_before_edge", s_axis_tready, 0);
        @(posedge clk); #1;
        check("rel_s_tready", s_axis_tready, 1);

        // 1: good 3-beat packet, latency from commit
        send_pkt(1, 3, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1);
        check("t1_valid_c1", m_axis_tvalid, 0);
        @(posedge clk); #1;
        check("t1_valid_c2", m_axis_tvalid, 1);
        drain("t1");

        // 2: errored 4-beat packet then good 2-beat packet (tuser on a non-last beat is ignored)
        send_pkt(2, 4, 1'b1, '1, 1'b0, 1'b0);
        exp_drops++;
        send_pkt(3, 2, 1'b0, 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
        drain("t2");
`ifdef XDMA_C2H_DROP_CNT_EN
        check("t2_drop_cnt", drop_cnt, exp_drops);
`endif

        // 3: 20-beat packet overflows a 16-beat buffer, then an 8-beat packet survives
        m_axis_tready = 1'b0;
        send_pkt(4, 20, 1'b0, '1, 1'b0, 1'b0);
        exp_drops++;
        repeat (4) @(posedge clk);
        #1 check("t3_no_output", m_axis_tvalid, 0);
        send_pkt(5, 8, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 m_axis_tready = 1'b1;
        drain("t3");
`ifdef XDMA_C2H_DROP_CNT_EN
        check("t3_drop_cnt", drop_cnt, exp_drops);
`endif

        // 4: 100 back-to-back 1-beat packets at full rate
        base = rx_q.size();
        for (int p = 0; p < 100; p++) send_pkt(100 + p, 1, 1'b0, 64'h1 << (p % 64), 1'b0, 1'b1);
        drain("t4");
        if (rx_q.size() - base == 100) check("t4_span", rx_cyc[base + 99] - rx_cyc[base], 99);

        // 5: 200 random packets with random output backpressure
        base = rx_q.size();
        good = 0;
        fork
            begin
                for (int p = 0; p < 200; p++) begin
                    len = $urandom_range(1, 12);
                    err = ($urandom_range(0, 7) == 0);
                    k = {$urandom(), $urandom()} | 64'h1;
                    for (int w = 0; w < 400 && (good - (rx_q.size() - base) + len > 16); w++) begin
                        @(posedge clk); #1;
                    end
                    send_pkt(1000 + p, len, err, k, 1'b0, !err);
                    if (err) exp_drops++;
                    else     good += len;
                end
                t5_done = 1'b1;
            end
            begin
                while (!t5_done) begin
                    @(posedge clk); #1;
                    m_axis_tready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        m_axis_tready = 1'b1;
        drain("t5");
        check("t5_hold_events_seen", n_hold_ev > 0, 1);
        check("t5_hold_violations", n_hold_bad, 0);
`ifdef XDMA_C2H_DROP_CNT_EN
        check("t5_drop_cnt", drop_cnt, exp_drops);
`endif

        // 6: reset in the middle of a packet with a packet waiting at the output
        m_axis_tready = 1'b0;
        send_pkt(6000, 2, 1'b0, '1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 check("t6_pre_valid", m_axis_tvalid, 1);
        for (int b = 0; b < 2; b++) begin
            s_axis_tdata = mk_data(6001, b); s_axis_tkeep = '1; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            if (b == 0) begin
                @(posedge clk); #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_m_tvalid_in_reset", m_axis_tvalid, 0);
        check("t6_s_tready_in_reset", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        exp_drops = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        rx_base = rx_q.size();
        send_pkt(6002, 3, 1'b0, 64'h0000_0000_0000_000F, 1'b0, 1'b1);
        drain("t6");
`ifdef XDMA_C2H_DROP_CNT_EN
        check("t6_drop_cnt", drop_cnt, exp_drops);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
